// File: rtl/axis_red_pitaya_adc_v3.sv
// Two-channel Red Pitaya ADC front end with boxcar decimation and triggered AXI-Stream capture.
// Optional build macro ADC_TEST_PATTERN_EN adds cfg_test, which swaps the ADC data for a counter pattern.
module axis_red_pitaya_adc_v3 #(
  parameter int ADC_DATA_WIDTH   = 14,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int MAX_LOG2_DECIM   = 6,
  parameter int LEN_WIDTH        = 16
) (
  input  logic                                    aclk,
  input  logic                                    aresetn,
  output logic                                    adc_csn,
  input  logic [ADC_DATA_WIDTH-1:0]               adc_dat_a,
  input  logic [ADC_DATA_WIDTH-1:0]               adc_dat_b,
  input  logic [$clog2(MAX_LOG2_DECIM+1)-1:0]     cfg_log2_decim,
  input  logic [LEN_WIDTH-1:0]                    cfg_len,
  input  logic                                    arm,
  input  logic                                    trig,
`ifdef ADC_TEST_PATTERN_EN
  input  logic                                    cfg_test,
`endif
  input  logic                                    m_axis_tready,
  output logic                                    m_axis_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0]             m_axis_tdata,
  output logic                                    m_axis_tlast,
  output logic                                    sts_busy,
  output logic                                    sts_overflow
);
  // state     | meaning
  // S_IDLE    | waiting for arm with a non-zero length
  // S_ARMED   | waiting for trig
  // S_CAPTURE | averaging and offering samples until cfg_len beats are loaded
  localparam int DW    = $clog2(MAX_LOG2_DECIM+1);
  localparam int ACC_W = ADC_DATA_WIDTH + MAX_LOG2_DECIM;
  localparam int HALF  = AXIS_TDATA_WIDTH / 2;
  localparam int EXT   = HALF - ADC_DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE} state_t;

  state_t                         state, state_nxt;
  logic [ADC_DATA_WIDTH-1:0]      raw_a, raw_b;
  logic signed [ADC_DATA_WIDTH-1:0] conv_a, conv_b;
  logic [DW-1:0]                  d_q, d_clamp;
  logic [LEN_WIDTH-1:0]           remaining;
  logic [MAX_LOG2_DECIM-1:0]      phase, phase_mask;
  logic signed [ACC_W-1:0]        acc_a, acc_b, ext_a, ext_b, sum_a, sum_b, avg_a, avg_b;
  logic                           dec_valid;
  logic [ADC_DATA_WIDTH-1:0]      dec_a, dec_b;
  logic                           first, phase_end, arm_ok, load, drop;

  assign adc_csn = 1'b1;

`ifdef ADC_TEST_PATTERN_EN
  logic signed [ADC_DATA_WIDTH-1:0] tp_cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) tp_cnt <= '0;
    else          tp_cnt <= tp_cnt + ADC_DATA_WIDTH'(1);
  end
`endif

  // Inverted offset binary: keep the MSB, flip the rest.
  always_comb begin
    conv_a = {raw_a[ADC_DATA_WIDTH-1], ~raw_a[ADC_DATA_WIDTH-2:0]};
    conv_b = {raw_b[ADC_DATA_WIDTH-1], ~raw_b[ADC_DATA_WIDTH-2:0]};
`ifdef ADC_TEST_PATTERN_EN
    if (cfg_test) begin
      conv_a = tp_cnt;
      conv_b = -tp_cnt;
    end
`endif
  end

  assign d_clamp    = (cfg_log2_decim > DW'(MAX_LOG2_DECIM)) ? DW'(MAX_LOG2_DECIM) : cfg_log2_decim;
  assign phase_mask = ~({MAX_LOG2_DECIM{1'b1}} << d_q);
  assign first      = (phase == phase_mask);
  assign phase_end  = (phase == '0);

  always_comb begin
    ext_a = {{MAX_LOG2_DECIM{conv_a[ADC_DATA_WIDTH-1]}}, conv_a};
    ext_b = {{MAX_LOG2_DECIM{conv_b[ADC_DATA_WIDTH-1]}}, conv_b};
    sum_a = first ? ext_a : acc_a + ext_a;
    sum_b = first ? ext_b : acc_b + ext_b;
    avg_a = sum_a >>> d_q;
    avg_b = sum_b >>> d_q;
  end

  // A pending last beat in IDLE still counts as busy, so arm waits for it.
  assign arm_ok   = arm && (cfg_len != '0) && !m_axis_tvalid;
  assign load     = (state == S_CAPTURE) && dec_valid && (!m_axis_tvalid || m_axis_tready);
  assign drop     = (state == S_CAPTURE) && dec_valid && m_axis_tvalid && !m_axis_tready;
  assign sts_busy = (state != S_IDLE) || m_axis_tvalid;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (arm_ok) state_nxt = S_ARMED;
      S_ARMED:   if (trig) state_nxt = S_CAPTURE;
      S_CAPTURE: if (load && remaining == LEN_WIDTH'(1)) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      raw_a     <= '0;
      raw_b     <= '0;
      d_q       <= '0;
      remaining <= '0;
      phase     <= '0;
      acc_a     <= '0;
      acc_b     <= '0;
      dec_valid <= 1'b0;
      dec_a     <= '0;
      dec_b     <= '0;
    end else begin
      raw_a <= adc_dat_a;
      raw_b <= adc_dat_b;
      if (state == S_IDLE && arm_ok) begin
        d_q       <= d_clamp;
        remaining <= cfg_len;
      end else if (load) begin
        remaining <= remaining - LEN_WIDTH'(1);
      end
      if (state != S_CAPTURE) begin
        phase     <= phase_mask;
        acc_a     <= '0;
        acc_b     <= '0;
        dec_valid <= 1'b0;
      end else begin
        acc_a <= sum_a;
        acc_b <= sum_b;
        if (phase_end) begin
          phase     <= phase_mask;
          dec_valid <= 1'b1;
          dec_a     <= avg_a[ADC_DATA_WIDTH-1:0];
          dec_b     <= avg_b[ADC_DATA_WIDTH-1:0];
        end else begin
          phase     <= phase - MAX_LOG2_DECIM'(1);
          dec_valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      sts_overflow  <= 1'b0;
    end else begin
      if (load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= (remaining == LEN_WIDTH'(1));
        m_axis_tdata  <= {{EXT{dec_b[ADC_DATA_WIDTH-1]}}, dec_b,
                          {EXT{dec_a[ADC_DATA_WIDTH-1]}}, dec_a};
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end
      if (state == S_IDLE && arm_ok) sts_overflow <= 1'b0;
      else if (drop)                 sts_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axis_red_pitaya_adc_v3.sv
// Scoreboard bench for axis_red_pitaya_adc_v3: a packet-level model predicts beats, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_axis_red_pitaya_adc_v3;
  localparam int W     = 14;
  localparam int MAXD  = 6;
  localparam int LW    = 16;
  localparam int STIM  = 600;
  localparam int HALFV = (1 << (W-1)) - 1;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          adc_csn;
  logic [W-1:0]  adc_dat_a = '0, adc_dat_b = '0;
  logic [2:0]    cfg_log2_decim = '0;
  logic [LW-1:0] cfg_len = '0;
  logic          arm = 1'b0, trig = 1'b0;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tvalid;
  logic [31:0]   m_axis_tdata;
  logic          m_axis_tlast;
  logic          sts_busy, sts_overflow;
`ifdef ADC_TEST_PATTERN_EN
  logic          cfg_test = 1'b0;
`endif

  axis_red_pitaya_adc_v3 dut (
    .aclk(aclk), .aresetn(aresetn), .adc_csn(adc_csn),
    .adc_dat_a(adc_dat_a), .adc_dat_b(adc_dat_b),
    .cfg_log2_decim(cfg_log2_decim), .cfg_len(cfg_len),
    .arm(arm), .trig(trig),
`ifdef ADC_TEST_PATTERN_EN
    .cfg_test(cfg_test),
`endif
    .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .sts_busy(sts_busy), .sts_overflow(sts_overflow)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [31:0] data; logic last; int at_edge; } exp_t;
  exp_t sbq[$];
  int errors = 0, checks = 0, cyc = 0, beats = 0;
  int stim_a[STIM], stim_b[STIM];
  bit rdy[STIM];
  logic        prev_valid = 1'b0, prev_hs = 1'b0, prev_last = 1'b0;
  logic [31:0] prev_data = '0, last_hs_data = '0;
  bit          mon_tp = 1'b0, tp_have = 1'b0;
  logic [W-1:0] tp_prev = '0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] to_raw(input int s);
    int r;
    r = HALFV - s;
    return r[W-1:0];
  endfunction

  // Monitor: compare each newly presented beat, and check stability while stalled.
  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (prev_valid && !prev_hs) begin
        chk("hold_valid", m_axis_tvalid, 1'b1);
        chk("hold_data", m_axis_tdata, prev_data);
        chk("hold_last", m_axis_tlast, prev_last);
      end
      if (m_axis_tvalid && (!prev_valid || prev_hs)) begin
        if (mon_tp) begin
          logic [W-1:0] nb;
          nb = -m_axis_tdata[W-1:0];
          if (tp_have) chk("tp_a_step", m_axis_tdata[W-1:0], tp_prev + 1'b1);
          chk("tp_b_neg", m_axis_tdata[31:16], {{(16-W){nb[W-1]}}, nb});
          tp_prev = m_axis_tdata[W-1:0];
          tp_have = 1'b1;
        end else if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got tdata %h, expected no beat (cycle %0d)", m_axis_tdata, cyc);
        end else begin
          chk("beat_edge", cyc, sbq[0].at_edge);
          chk("beat_data", m_axis_tdata, sbq[0].data);
          chk("beat_last", m_axis_tlast, sbq[0].last);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        beats++;
        last_hs_data = m_axis_tdata;
        if (!mon_tp && sbq.size() > 0) void'(sbq.pop_front());
      end
      prev_valid = m_axis_tvalid;
      prev_hs    = m_axis_tvalid && m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic fill_random(input int rdy_pct);
    for (int i = 0; i < STIM; i++) begin
      stim_a[i] = HALFV - int'($urandom_range(0, (1 << W) - 1));
      stim_b[i] = HALFV - int'($urandom_range(0, (1 << W) - 1));
      rdy[i]    = (i >= 300) || ($urandom_range(0, 99) < rdy_pct);
    end
  endtask

  // Model: group averages of 2^D samples starting at the trigger edge; group k is offered
  // to a one-entry buffer at edge (k+1)*2^D+1 and dropped if the buffer is still occupied.
  task automatic run_packet(input int d, input int len, input int rst_at, input bit pre_armed, input bit arm_mid);
    int de, n, k, acc, done_e, base, tmo, beats0, s, sb;
    bit full, ovf;
    logic [31:0] words[$];
    exp_t x;
    de = (d > MAXD) ? MAXD : d;
    n  = 1 << de;
    if (!pre_armed) begin
      tmo = 0;
      while (sts_busy && tmo < 2000) begin tick(); tmo++; end
      if (tmo >= 2000) chk("idle_timeout", sts_busy, 1'b0);
      cfg_log2_decim = 3'(d);
      cfg_len = LW'(len);
      arm = 1'b1;
      tick();
      arm = 1'b0;
      cfg_log2_decim = 3'($urandom);
      cfg_len = LW'($urandom);
      chk("busy_after_arm", sts_busy, 1'b1);
      repeat ($urandom_range(0, 3)) tick();
    end
    for (k = 0; (k + 1) * n <= STIM; k++) begin
      s = 0;
      sb = 0;
      for (int j = 0; j < n; j++) begin
        s  += stim_a[k*n + j];
        sb += stim_b[k*n + j];
      end
      s  = s >>> de;
      sb = sb >>> de;
      words.push_back({sb[15:0], s[15:0]});
    end
    base = cyc + 1;
    full = 0; ovf = 0; acc = 0; done_e = -1;
    for (int e = 0; e < STIM && acc < len; e++) begin
      if (full && rdy[e]) full = 0;
      if (e >= n + 1 && (e - 1) % n == 0) begin
        k = (e - 1) / n - 1;
        if (!full) begin
          x.data = words[k];
          x.last = (acc + 1 == len);
          x.at_edge = base + e;
          sbq.push_back(x);
          acc++;
          full = 1;
          done_e = e;
        end else begin
          ovf = 1;
        end
      end
    end
    beats0 = beats;
    for (int e = 0; e <= done_e; e++) begin
      adc_dat_a = to_raw(stim_a[e]);
      adc_dat_b = to_raw(stim_b[e]);
      m_axis_tready = rdy[e];
      trig = (e == 0);
      if (arm_mid && e == done_e / 2) begin
        arm = 1'b1;
        cfg_len = LW'(1);
        cfg_log2_decim = 3'd0;
      end else begin
        arm = 1'b0;
      end
      tick();
      if (rst_at > 0 && beats - beats0 >= rst_at) begin
        aresetn = 1'b0;
        #1;
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_tlast", m_axis_tlast, 1'b0);
        chk("rst_tdata", m_axis_tdata, 32'h0);
        chk("rst_busy", sts_busy, 1'b0);
        chk("rst_overflow", sts_overflow, 1'b0);
        sbq.delete();
        arm = 1'b0;
        trig = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        aresetn = 1'b1;
        return;
      end
    end
    arm = 1'b0;
    trig = 1'b0;
    m_axis_tready = 1'b1;
    tmo = 0;
    while (sbq.size() > 0 && tmo < 500) begin
      adc_dat_a = W'($urandom);
      adc_dat_b = W'($urandom);
      tick();
      tmo++;
    end
    if (tmo >= 500) begin
      chk("drain_timeout", 64'(sbq.size()), 64'd0);
      sbq.delete();
    end
    chk("pkt_beats", 64'(beats - beats0), 64'(len));
    chk("pkt_overflow", sts_overflow, ovf);
    chk("pkt_busy_done", sts_busy, 1'b0);
    chk("pkt_tvalid_done", m_axis_tvalid, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_tvalid", m_axis_tvalid, 1'b0);
    chk("reset_tlast", m_axis_tlast, 1'b0);
    chk("reset_tdata", m_axis_tdata, 32'h0);
    chk("reset_busy", sts_busy, 1'b0);
    chk("reset_overflow", sts_overflow, 1'b0);
    chk("adc_csn", adc_csn, 1'b1);
    aresetn = 1'b1;
    tick();

    // Constant raw A=0x0000, B=0x3FFF
    for (int i = 0; i < STIM; i++) begin stim_a[i] = 8191; stim_b[i] = -8192; rdy[i] = 1; end
    run_packet(0, 4, 0, 0, 0);
    chk("conv_word", last_hs_data, 32'hE000_1FFF);

    // Decimation by 4: 4,8,12,16 -> 10
    for (int i = 0; i < STIM; i++) begin stim_a[i] = 4 * ((i % 4) + 1); stim_b[i] = 0; rdy[i] = 1; end
    run_packet(2, 3, 0, 0, 0);
    chk("decim_avg", last_hs_data, 32'h0000_000A);

    // Negative sum -3 over 4 samples -> -1
    for (int i = 0; i < STIM; i++) begin stim_a[i] = (i % 4 == 3) ? 0 : -1; stim_b[i] = 0; rdy[i] = 1; end
    run_packet(2, 2, 0, 0, 0);
    chk("decim_floor", last_hs_data, 32'h0000_FFFF);

    // Backpressure during packet cycles 3-6
    fill_random(100);
    for (int i = 3; i <= 6; i++) rdy[i] = 0;
    run_packet(0, 8, 0, 0, 0);
    chk("bp_overflow", sts_overflow, 1'b1);

    // Arm with zero length is ignored
    cfg_len = '0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    chk("arm_len0_busy", sts_busy, 1'b0);

    // Arm and trig together: armed only
    cfg_log2_decim = 3'd1;
    cfg_len = LW'(3);
    arm = 1'b1;
    trig = 1'b1;
    tick();
    arm = 1'b0;
    trig = 1'b0;
    repeat (10) tick();
    chk("armtrig_busy", sts_busy, 1'b1);
    chk("armtrig_novalid", m_axis_tvalid, 1'b0);
    fill_random(80);
    run_packet(1, 3, 0, 1, 0);

    // Second arm during capture is ignored
    fill_random(100);
    run_packet(0, 6, 0, 0, 1);

    // Reset at beat 2, then a normal packet
    fill_random(100);
    run_packet(0, 6, 2, 0, 0);
    fill_random(100);
    run_packet(0, 4, 0, 0, 0);

    for (int it = 0; it < 6; it++) begin
      fill_random(70);
      run_packet(int'($urandom_range(0, 3)), int'($urandom_range(1, 10)), 0, 0, 0);
    end
    fill_random(100);
    run_packet(7, 2, 0, 0, 0);

`ifdef ADC_TEST_PATTERN_EN
    cfg_test = 1'b1;
    mon_tp = 1'b1;
    tp_have = 1'b0;
    cfg_log2_decim = 3'd0;
    cfg_len = LW'(5);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    trig = 1'b1;
    m_axis_tready = 1'b1;
    tick();
    trig = 1'b0;
    repeat (12) tick();
    chk("tp_busy_done", sts_busy, 1'b0);
    mon_tp = 1'b0;
    cfg_test = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
